pbvi_backup_argmax: RTL and testbench

- Parametrised PBVI backup-selection engine.
- For each of NUM_POINTS belief points, it computes the dot product of the belief with every action's candidate alpha vector and selects the action with the maximum value.
- It registers the winning action index, the winning alpha vector and the winning value.
- Sits after the gamma-action-belief generation stage; done feeds the value-iteration loop controller. A time-multiplexed MAC is used per point lane, one (action, state) term per cycle, with start/busy/done handshake.

---
 rtl/pbvi_backup_argmax_if.sv | 22 ++
 rtl/pbvi_backup_argmax.sv | 89 ++++++++
 tb/tb_pbvi_backup_argmax.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pbvi_backup_argmax_if.sv
// pbvi_backup_argmax_if: start/busy/done handshake plus operand and result buses of the backup engine
interface pbvi_backup_argmax_if #(
    parameter int NUM_POINTS  = 16,
    parameter int NUM_STATES  = 2,
    parameter int NUM_ACTIONS = 3,
    parameter int DATA_W      = 16,
    parameter int ACT_W       = (NUM_ACTIONS > 1 ? $clog2(NUM_ACTIONS) : 1)
);
    localparam int ACC_W = 2*DATA_W + $clog2(NUM_STATES) + 1;
    logic                                                          start;
    logic [NUM_ACTIONS-1:0][NUM_POINTS-1:0][NUM_STATES-1:0][DATA_W-1:0] gamma_action_belief;
    logic [NUM_POINTS-1:0][NUM_STATES-1:0][DATA_W-1:0]             point_belief;
    logic                                                          busy;
    logic                                                          done;
    logic [NUM_POINTS-1:0][ACT_W-1:0]                              point_action;
    logic [NUM_POINTS-1:0][NUM_STATES-1:0][DATA_W-1:0]             alpha;
    logic [NUM_POINTS-1:0][ACC_W-1:0]                              best_val;
    modport master (output start, gamma_action_belief, point_belief,
                    input  busy, done, point_action, alpha, best_val);
    modport slave  (input  start, gamma_action_belief, point_belief,
                    output busy, done, point_action, alpha, best_val);
endinterface

// File: rtl/pbvi_backup_argmax.sv
// pbvi_backup_argmax: per-lane time-multiplexed dot products with running argmax over candidate alpha vectors
module pbvi_backup_argmax #(
    parameter int NUM_POINTS  = 16,
    parameter int NUM_STATES  = 2,
    parameter int NUM_ACTIONS = 3,
    parameter int DATA_W      = 16,
    parameter int ACT_W       = (NUM_ACTIONS > 1 ? $clog2(NUM_ACTIONS) : 1)
) (
    input logic                 clk,
    input logic                 rst_n,
    pbvi_backup_argmax_if.slave bus
);
    localparam int ACC_W = 2*DATA_W + $clog2(NUM_STATES) + 1;
    localparam int S_W   = NUM_STATES > 1 ? $clog2(NUM_STATES) : 1;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t                                                             state, state_nx;
    logic [NUM_POINTS-1:0][NUM_STATES-1:0][DATA_W-1:0]                  belief_r, cand_alpha;
    logic [NUM_ACTIONS-1:0][NUM_POINTS-1:0][NUM_STATES-1:0][DATA_W-1:0] gamma_r;
    logic [NUM_POINTS-1:0][ACC_W-1:0]                                   acc, sum, cand_val;
    logic [NUM_POINTS-1:0][ACT_W-1:0]                                   cand_act;
    logic [NUM_POINTS-1:0]                                              upd;
    logic [S_W-1:0]                                                     s_cnt;
    logic [ACT_W-1:0]                                                   a_cnt;
    logic                                                               last_s, last_a;
    assign last_s   = s_cnt == S_W'(NUM_STATES - 1);
    assign last_a   = a_cnt == ACT_W'(NUM_ACTIONS - 1);
    assign bus.busy = state != IDLE;
    assign bus.done = state == DONE;
    // next state: accept start only in IDLE, leave CALC after the last term of the last action
    always_comb begin
        state_nx = state == IDLE ? (bus.start ? CALC : IDLE) :
                   state == CALC ? (last_s && last_a ? DONE : CALC) : IDLE;
    end
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    // one MAC term per lane; a lane adopts the finished vector on the first action or a strictly larger value
    always_comb begin
        sum = '0;
        upd = '0;
        for (int p = 0; p < NUM_POINTS; p++) begin
            sum[p] = acc[p] + ACC_W'(belief_r[p][s_cnt] * gamma_r[a_cnt][p][s_cnt]);
            upd[p] = (a_cnt == '0) || (sum[p] > cand_val[p]);
        end
    end
    // operand capture, accumulation, candidate tracking and result publication on the final term
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            belief_r         <= '0;
            gamma_r          <= '0;
            acc              <= '0;
            cand_val         <= '0;
            cand_act         <= '0;
            cand_alpha       <= '0;
            s_cnt            <= '0;
            a_cnt            <= '0;
            bus.point_action <= '0;
            bus.alpha        <= '0;
            bus.best_val     <= '0;
        end else if (state == IDLE && bus.start) begin
            belief_r <= bus.point_belief;
            gamma_r  <= bus.gamma_action_belief;
            acc      <= '0;
            s_cnt    <= '0;
            a_cnt    <= '0;
        end else if (state == CALC && !last_s) begin
            acc   <= sum;
            s_cnt <= s_cnt + 1'b1;
        end else if (state == CALC) begin
            acc   <= '0;
            s_cnt <= '0;
            a_cnt <= a_cnt + 1'b1;
            for (int p = 0; p < NUM_POINTS; p++) begin
                if (upd[p]) begin
                    cand_val[p]   <= sum[p];
                    cand_act[p]   <= a_cnt;
                    cand_alpha[p] <= gamma_r[a_cnt][p];
                end
                if (last_a) begin
                    bus.point_action[p] <= upd[p] ? a_cnt : cand_act[p];
                    bus.alpha[p]        <= upd[p] ? gamma_r[a_cnt][p] : cand_alpha[p];
                    bus.best_val[p]     <= upd[p] ? sum[p] : cand_val[p];
                end
            end
        end
    end
endmodule

// File: tb/tb_pbvi_backup_argmax.sv
// tb_pbvi_backup_argmax: scoreboard bench for default and swept configurations of the backup engine
module tb_pbvi_backup_argmax;
    localparam int P = 16, S = 2, A = 3, D = 16, AW = 2, CW = 2*D + 1 + 1;
    localparam int P1 = 4, S1 = 4, A1 = 5, D1 = 8, AW1 = 3, CW1 = 2*D1 + 2 + 1;
    typedef logic [A-1:0][P-1:0][S-1:0][D-1:0]     g0_t;
    typedef logic [P-1:0][S-1:0][D-1:0]            b0_t;
    typedef logic [A1-1:0][P1-1:0][S1-1:0][D1-1:0] g1_t;
    typedef logic [P1-1:0][S1-1:0][D1-1:0]         b1_t;
    typedef struct {
        int                    cyc;
        logic [P-1:0][AW-1:0]  pa;
        b0_t                   al;
        logic [P-1:0][CW-1:0]  bv;
    } e0_t;
    typedef struct {
        int                     cyc;
        logic [P1-1:0][AW1-1:0] pa;
        b1_t                    al;
        logic [P1-1:0][CW1-1:0] bv;
    } e1_t;

    logic clk = 0;
    logic rst_n = 0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    e0_t  q0[$];
    e1_t  q1[$];

    pbvi_backup_argmax_if #(.NUM_POINTS(P), .NUM_STATES(S), .NUM_ACTIONS(A), .DATA_W(D), .ACT_W(AW)) bus0();
    pbvi_backup_argmax_if #(.NUM_POINTS(P1), .NUM_STATES(S1), .NUM_ACTIONS(A1), .DATA_W(D1), .ACT_W(AW1)) bus1();

    pbvi_backup_argmax #(.NUM_POINTS(P), .NUM_STATES(S), .NUM_ACTIONS(A), .DATA_W(D), .ACT_W(AW)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    pbvi_backup_argmax #(.NUM_POINTS(P1), .NUM_STATES(S1), .NUM_ACTIONS(A1), .DATA_W(D1), .ACT_W(AW1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string n, input logic [575:0] act, input logic [575:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", n, act, exp);
        end
    endtask

    function automatic e0_t model0(input g0_t g, input b0_t b);
        e0_t e;
        logic [CW-1:0] v, best;
        int act;
        e.cyc = 0;
        for (int p = 0; p < P; p++) begin
            best = '0;
            act = 0;
            for (int a = 0; a < A; a++) begin
                v = '0;
                for (int s = 0; s < S; s++) v = v + CW'(b[p][s]) * CW'(g[a][p][s]);
                if (a == 0 || v > best) begin best = v; act = a; end
            end
            e.pa[p] = AW'(act);
            e.al[p] = g[act][p];
            e.bv[p] = best;
        end
        return e;
    endfunction

    function automatic e1_t model1(input g1_t g, input b1_t b);
        e1_t e;
        logic [CW1-1:0] v, best;
        int act;
        e.cyc = 0;
        for (int p = 0; p < P1; p++) begin
            best = '0;
            act = 0;
            for (int a = 0; a < A1; a++) begin
                v = '0;
                for (int s = 0; s < S1; s++) v = v + CW1'(b[p][s]) * CW1'(g[a][p][s]);
                if (a == 0 || v > best) begin best = v; act = a; end
            end
            e.pa[p] = AW1'(act);
            e.al[p] = g[act][p];
            e.bv[p] = best;
        end
        return e;
    endfunction

    function automatic g0_t mkg0(input logic [D-1:0] a00, a01, a10, a11, a20, a21);
        g0_t g;
        for (int p = 0; p < P; p++) begin
            g[0][p][0] = a00; g[0][p][1] = a01;
            g[1][p][0] = a10; g[1][p][1] = a11;
            g[2][p][0] = a20; g[2][p][1] = a21;
        end
        return g;
    endfunction

    function automatic b0_t mkb0(input logic [D-1:0] x0, x1);
        b0_t b;
        for (int p = 0; p < P; p++) begin b[p][0] = x0; b[p][1] = x1; end
        return b;
    endfunction

    function automatic e0_t rep0(input int a, input logic [D-1:0] x0, x1, input logic [CW-1:0] v);
        e0_t e;
        e.cyc = 0;
        for (int p = 0; p < P; p++) begin
            e.pa[p] = AW'(a); e.al[p][0] = x0; e.al[p][1] = x1; e.bv[p] = v;
        end
        return e;
    endfunction

    function automatic g0_t rndg0();
        g0_t g;
        for (int a = 0; a < A; a++)
            for (int p = 0; p < P; p++)
                for (int s = 0; s < S; s++) g[a][p][s] = D'($urandom);
        return g;
    endfunction

    function automatic b0_t rndb0();
        b0_t b;
        for (int p = 0; p < P; p++)
            for (int s = 0; s < S; s++) b[p][s] = D'($urandom);
        return b;
    endfunction

    function automatic g1_t rndg1(input int mx);
        g1_t g;
        for (int a = 0; a < A1; a++)
            for (int p = 0; p < P1; p++)
                for (int s = 0; s < S1; s++) g[a][p][s] = D1'($urandom_range(0, mx));
        return g;
    endfunction

    function automatic b1_t rndb1(input int mx);
        b1_t b;
        for (int p = 0; p < P1; p++)
            for (int s = 0; s < S1; s++) b[p][s] = D1'($urandom_range(0, mx));
        return b;
    endfunction

    task automatic issue0(input g0_t g, input b0_t b, input e0_t e);
        bus0.gamma_action_belief = g;
        bus0.point_belief = b;
        bus0.start = 1;
        e.cyc = cyc + 1 + A*S;
        q0.push_back(e);
        @(negedge clk);
        bus0.start = 0;
        repeat (A*S + 2) @(negedge clk);
    endtask

    task automatic issue1(input g1_t g, input b1_t b);
        e1_t e;
        e = model1(g, b);
        bus1.gamma_action_belief = g;
        bus1.point_belief = b;
        bus1.start = 1;
        e.cyc = cyc + 1 + A1*S1;
        q1.push_back(e);
        @(negedge clk);
        bus1.start = 0;
        repeat (A1*S1 + 2) @(negedge clk);
    endtask

    // default-configuration monitor: every done must match the oldest expected run, in time and content
    always @(negedge clk) begin
        if (bus0.done) begin
            check("done0_expected", q0.size() != 0, 1);
            if (q0.size() != 0) begin
                e0_t e;
                e = q0.pop_front();
                check("done0_cycle", cyc, e.cyc);
                check("point_action0", bus0.point_action, e.pa);
                check("alpha0", bus0.alpha, e.al);
                check("best_val0", bus0.best_val, e.bv);
            end
        end
    end

    // swept-configuration monitor
    always @(negedge clk) begin
        if (bus1.done) begin
            check("done1_expected", q1.size() != 0, 1);
            if (q1.size() != 0) begin
                e1_t e;
                e = q1.pop_front();
                check("done1_cycle", cyc, e.cyc);
                check("point_action1", bus1.point_action, e.pa);
                check("alpha1", bus1.alpha, e.al);
                check("best_val1", bus1.best_val, e.bv);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout actual=cycle %0d required=completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        g0_t ga, gb;
        b0_t ba, bb;
        bus0.start = 0;
        bus0.gamma_action_belief = '0;
        bus0.point_belief = '0;
        bus1.start = 0;
        bus1.gamma_action_belief = '0;
        bus1.point_belief = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus0.busy, 0);
        check("rst_done", bus0.done, 0);
        check("rst_action", bus0.point_action, 0);
        check("rst_alpha", bus0.alpha, 0);
        check("rst_best_val", bus0.best_val, 0);
        check("rst_busy1", bus1.busy, 0);
        rst_n = 1;
        @(negedge clk);

        bus0.gamma_action_belief = mkg0(2, 2, 4, 1, 1, 3);
        bus0.point_belief = mkb0(3, 5);
        begin
            e0_t e;
            e = rep0(2, 1, 3, 18);
            e.cyc = cyc + 1 + A*S;
            q0.push_back(e);
        end
        bus0.start = 1;
        for (int k = 0; k <= 8; k++) begin
            check("busy_window", bus0.busy, k >= 1 && k <= 7);
            @(negedge clk);
            bus0.start = 0;
        end

        issue0(mkg0(2, 3, 3, 2, 1, 1), mkb0(1, 1), rep0(0, 2, 3, 5));
        issue0(mkg0(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), mkb0(16'hFFFF, 16'hFFFF),
               rep0(0, 16'hFFFF, 16'hFFFF, 34'h1_FFFC_0002));
        issue0(mkg0(0, 0, 0, 0, 0, 0), mkb0(0, 0), rep0(0, 0, 0, 0));
        repeat (4) begin
            ga = rndg0();
            ba = rndb0();
            issue0(ga, ba, model0(ga, ba));
        end

        ga = rndg0();
        ba = rndb0();
        bus0.gamma_action_belief = ga;
        bus0.point_belief = ba;
        begin
            e0_t e;
            e = model0(ga, ba);
            e.cyc = cyc + 1 + A*S;
            q0.push_back(e);
        end
        for (int k = 0; k < 12; k++) begin
            bus0.start = k == 0 || k == 3 || k == 7;
            if (k == 2) begin
                bus0.gamma_action_belief = rndg0();
                bus0.point_belief = rndb0();
            end
            @(negedge clk);
        end
        bus0.start = 0;
        check("ignored_starts_idle", bus0.busy, 0);

        ga = rndg0();
        ba = rndb0();
        gb = rndg0();
        bb = rndb0();
        bus0.gamma_action_belief = ga;
        bus0.point_belief = ba;
        begin
            e0_t e;
            e = model0(ga, ba);
            e.cyc = cyc + 1 + A*S;
            q0.push_back(e);
        end
        bus0.start = 1;
        for (int k = 0; k <= 8; k++) begin
            if (k == 1) begin
                bus0.gamma_action_belief = gb;
                bus0.point_belief = bb;
            end
            if (k == 8) begin
                e0_t e;
                e = model0(gb, bb);
                e.cyc = cyc + 1 + A*S;
                q0.push_back(e);
            end
            @(negedge clk);
        end
        bus0.start = 0;
        repeat (10) @(negedge clk);

        bus0.gamma_action_belief = mkg0(9, 9, 9, 9, 9, 9);
        bus0.point_belief = mkb0(7, 7);
        bus0.start = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus0.start = 0;
        end
        rst_n = 0;
        #1;
        check("midrst_busy", bus0.busy, 0);
        check("midrst_done", bus0.done, 0);
        check("midrst_action", bus0.point_action, 0);
        check("midrst_alpha", bus0.alpha, 0);
        check("midrst_best_val", bus0.best_val, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (10) @(negedge clk);
        check("midrst_no_result", bus0.best_val, 0);
        issue0(mkg0(2, 2, 4, 1, 1, 3), mkb0(3, 5), rep0(2, 1, 3, 18));

        for (int i = 0; i < 1000; i++) issue1(rndg1(i % 2 ? 255 : 3), rndb1(i % 2 ? 255 : 3));

        repeat (5) @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
